// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared encodings for the memory-access stage: load/store kind codes, the
// transaction FSM state type and a misalignment helper.
// ---------------------------------------------------------------------------
package core_pkg;

   // Load kinds (info_loadE). Bits [1:0] give the access size.
   localparam logic [2:0] LD_NONE = 3'b000;
   localparam logic [2:0] LD_LB   = 3'b001;
   localparam logic [2:0] LD_LH   = 3'b010;
   localparam logic [2:0] LD_LW   = 3'b011;
   localparam logic [2:0] LD_LBU  = 3'b101;
   localparam logic [2:0] LD_LHU  = 3'b110;

   // Store kinds (info_storeE). The code doubles as the access size.
   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_SB   = 2'b01;
   localparam logic [1:0] ST_SH   = 2'b10;
   localparam logic [1:0] ST_SW   = 2'b11;

   // Access size shared by both encodings: 01 byte, 10 half, 11 word.
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,   // no transaction outstanding
      WAIT = 1'b1    // request issued, ack not yet seen
   } state_t;

   // Halfwords need bit 0 clear, words need both low bits clear.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] offset);
      return ((size == SZ_HALF) && offset[0]) ||
             ((size == SZ_WORD) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Selects the addressed lane of a read word and sign/zero-extends it.
//   i_rdata  : 32-bit word returned by data memory
//   i_offset : byte offset within the word (addr[1:0])
//   i_kind   : load kind (LD_* from core_pkg)
//   o_value  : extended 32-bit load result
// ---------------------------------------------------------------------------
module load_extend
   import core_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_kind,
   output logic [31:0] o_value
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_offset)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      // Halfword loads are aligned, so only offset bit 1 matters.
      w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
      o_value = '0;
      case (i_kind)
         LD_LB:   o_value = {{24{w_byte[7]}}, w_byte};
         LD_LBU:  o_value = {24'd0, w_byte};
         LD_LH:   o_value = {{16{w_half[15]}}, w_half};
         LD_LHU:  o_value = {16'd0, w_half};
         LD_LW:   o_value = i_rdata;
         default: o_value = '0;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// memory_access
// Memory stage of the RV32I pipeline. Issues req/ack transactions on the
// data-memory bus, steers store bytes onto lanes, extends load data and
// registers the writeback bundle. Stalls upstream while a transaction is open.
//   Execute bundle in : alu_result, rs2E, write_regE, info_loadE,
//                       info_storeE, dstreg_addrE
//   stall             : combinational upstream hold
//   Data-memory bus   : dmem_req/we/addr/wstrb/wdata out, dmem_ack/rdata in
//   Writeback out     : wb_data, write_regM, dstreg_addrM
//   misaligned        : one-cycle pulse on a misaligned access (no request)
// ---------------------------------------------------------------------------
module memory_access
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] alu_result,
   input  logic [31:0] rs2E,
   input  logic        write_regE,
   input  logic [2:0]  info_loadE,
   input  logic [1:0]  info_storeE,
   input  logic [4:0]  dstreg_addrE,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] wb_data,
   output logic        write_regM,
   output logic [4:0]  dstreg_addrM,
   output logic        misaligned
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_issue;
   logic        w_done;

   logic        w_is_store;
   logic        w_is_mem;
   logic        w_misal;
   logic [1:0]  w_size;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;
   logic [31:0] w_ld_value;

   // Fields latched at issue and consumed when the ack arrives.
   logic [1:0]  r_offset;
   logic [2:0]  r_ld_kind;
   logic        r_write;
   logic [4:0]  r_dst;

   // Decode: a store wins over a load when both are flagged.
   assign w_is_store = (info_storeE != ST_NONE);
   assign w_is_mem   = w_is_store || (info_loadE != LD_NONE);
   assign w_size     = w_is_store ? info_storeE : info_loadE[1:0];
   assign w_misal    = w_is_mem && is_misaligned(w_size, alu_result[1:0]);

   // Store lane steering; loads drive no strobes and zero data.
   always_comb begin
      w_wstrb = 4'b0000;
      w_wdata = '0;
      case (info_storeE)
         ST_SB: begin
            w_wstrb = 4'b0001 << alu_result[1:0];
            w_wdata = {4{rs2E[7:0]}};
         end
         ST_SH: begin
            w_wstrb = 4'b0011 << alu_result[1:0];
            w_wdata = {2{rs2E[15:0]}};
         end
         ST_SW: begin
            w_wstrb = 4'b1111;
            w_wdata = rs2E;
         end
         default: ;
      endcase
   end

   load_extend u_load_extend (
      .i_rdata  (dmem_rdata),
      .i_offset (r_offset),
      .i_kind   (r_ld_kind),
      .o_value  (w_ld_value)
   );

   // FSM next-state and stall.
   always_comb begin
      w_state_nxt = r_state;
      stall       = 1'b0;
      w_issue     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_is_mem && !w_misal) begin
               stall       = 1'b1;
               w_issue     = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            stall = !dmem_ack;
            if (dmem_ack) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state <= w_state_nxt;
      end
   end

   // Bus request, latched context and writeback bundle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wstrb   <= '0;
         dmem_wdata   <= '0;
         r_offset     <= '0;
         r_ld_kind    <= LD_NONE;
         r_write      <= 1'b0;
         r_dst        <= '0;
         wb_data      <= '0;
         write_regM   <= 1'b0;
         dstreg_addrM <= '0;
         misaligned   <= 1'b0;
      end else begin
         // Pulse outputs; a WAIT cycle without ack leaves a bubble.
         write_regM <= 1'b0;
         misaligned <= 1'b0;

         if (w_issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= w_is_store;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_wstrb <= w_wstrb;
            dmem_wdata <= w_wdata;
            r_offset   <= alu_result[1:0];
            r_ld_kind  <= w_is_store ? LD_NONE : info_loadE;
            r_write    <= write_regE;
            r_dst      <= dstreg_addrE;
         end else if (w_done) begin
            dmem_req <= 1'b0;
            // Request fields stay put; only loads write back.
            if (!dmem_we) begin
               wb_data      <= w_ld_value;
               write_regM   <= r_write;
               dstreg_addrM <= r_dst;
            end
         end else if (r_state == IDLE) begin
            if (w_misal) begin
               misaligned <= 1'b1;
            end else begin
               wb_data      <= alu_result;
               write_regM   <= write_regE;
               dstreg_addrM <= dstreg_addrE;
            end
         end
      end
   end

endmodule

// File: doc/memory_access.md
# memory_access

Memory-access stage of the five-stage RV32I pipeline, directly downstream of `execute`. It consumes the registered execute-stage bundle: `alu_result` as the address, `rs2E` as the store data, and `write_regE`, `info_loadE`, `info_storeE`, `dstreg_addrE` as the control fields. It runs a req/ack transaction on the data-memory bus and performs byte-lane steering and load extension. It stalls the upstream stages while a transaction is outstanding, then registers the writeback bundle for the writeback stage.

## Interface
Parameters:
- none.

Ports (name, direction, width, meaning):
- `clk`  in  1  — the single clock.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `alu_result`  in  32  — effective address, or ALU value for non-memory ops.
- `rs2E`  in  32  — store data.
- `write_regE`  in  1  — the instruction writes the register file.
- `info_loadE`  in  3  — load kind: 000 none, 001 LB, 010 LH, 011 LW, 101 LBU, 110 LHU.
- `info_storeE`  in  2  — store kind: 00 none, 01 SB, 10 SH, 11 SW.
- `dstreg_addrE`  in  5  — destination register.
- `stall`  out  1  — combinational; when high, upstream stages hold their registers.
- `dmem_req`  out  1  — transaction request, held high until ack.
- `dmem_we`  out  1  — 1 = write.
- `dmem_addr`  out  32  — word-aligned address, `{alu_result[31:2], 2'b00}`.
- `dmem_wstrb`  out  4  — byte-lane enables.
- `dmem_wdata`  out  32  — store data replicated onto the lanes.
- `dmem_ack`  in  1  — transaction complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  32  — read word.
- `wb_data`  out  32  — value to write back.
- `write_regM`  out  1  — writeback enable, exactly one cycle per instruction.
- `dstreg_addrM`  out  5  — writeback destination.
- `misaligned`  out  1  — one-cycle pulse on a misaligned access.

## Operation
States:
- IDLE — no transaction outstanding.
- WAIT — a transaction has been issued and ack has not yet been seen.

IDLE, no memory op (both info fields zero):
- Register `wb_data=alu_result`, `write_regM=write_regE`, `dstreg_addrM=dstreg_addrE`.
- `stall=0`.

IDLE, load or store:
- Misaligned when halfword and `addr[0]=1`, or word and `addr[1:0]!=0`.
- If misaligned: no request is issued. Register `misaligned=1` and `write_regM=0`; `stall=0`.
- Otherwise: `stall=1`. Next edge: go to WAIT, set `dmem_req=1`, and latch we/addr/wstrb/wdata together with `addr[1:0]`, the load kind and the destination.
- If both info fields are nonzero, the store takes precedence.

Store lane rules:
- SB: `wstrb = 0001 << addr[1:0]`; wdata = byte replicated ×4.
- SH: `wstrb = 0011 << addr[1:0]`; wdata = half replicated ×2.
- SW: `wstrb = 1111`.
- Loads: `wstrb = 0000`, `we = 0`.

WAIT:
- `stall = !dmem_ack`.
- On ack: `dmem_req=0`, go to IDLE.
- Load: register `wb_data` = the selected lane of `dmem_rdata` (offset `addr[1:0]`), sign-extended for LB/LH and zero-extended for LBU/LHU; `write_regM` = latched write flag.
- Store: `write_regM=0`.

Outputs while in WAIT without ack: `write_regM=0` (bubble). `wb_data` and `dstreg_addrM` hold their previous values.

## Timing
- Reset value of every output is 0; state resets to IDLE.
- Non-memory op: 1 cycle from input to writeback output.
- Memory op presented in cycle 0:
  - `stall` high in cycle 0.
  - `dmem_req` high from cycle 1 until the ack cycle, inclusive.
  - Ack in cycle k≥1 → writeback output in cycle k+1, `stall` low in cycle k.
- Request fields stay stable while `dmem_req=1`.
- Reset asserted during WAIT: return to IDLE immediately and drop `dmem_req`. An ack arriving after reset is ignored.
- `dmem_ack` while in IDLE is ignored.

## Structure
- Package `core_pkg`: load/store encodings (`LD_NONE/LB/LH/LW/LBU/LHU`, `ST_NONE/SB/SH/SW`) and the state enum.
- One sub-module, `load_extend`: combinational lane select plus sign/zero extension (rdata, offset, kind → 32-bit value).

## Test plan
- ALU passthrough: `alu_result=0x1234`, `write_regE=1`, `dst=5` → next cycle `wb_data=0x1234`, `write_regM=1`, `dstreg_addrM=5`, `stall` never high.
- LB at 0x103, `rdata=0x80FF_0000`, ack in the first WAIT cycle → `dmem_addr=0x100`, `wb_data=0xFFFF_FF80`; LBU at the same address → `wb_data=0x0000_0080`.
- SH at 0x202, `rs2=0xABCD_1234` → `wstrb=1100`, `wdata=0x1234_1234`, `we=1`, `write_regM=0`.
- LW with ack delayed 3 cycles after `req` → `stall` high throughout, `req` stable, exactly one `write_regM` pulse.
- LW at 0x101 → `misaligned` pulse, no `dmem_req`, `write_regM=0`, `stall=0`.
- `rst_n` low during WAIT → `dmem_req=0`, state IDLE; a late ack produces no writeback.
